// File: rtl/bit_serial_matrix_multiply_specific.sv
// ============================================================================
// Module  : bit_serial_matrix_multiply_specific
// Brief   : Bit-serial (LSB first) product of a 10-element vector and a fixed
//           15x10 matrix M[r][c] = ((r+2c) mod 4) - 1; 32 cycles per run.
//           Optional macro BSMM_RESULT_CLEAR_EN clears result at run start.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serial_matrix_multiply_specific #(
   parameter int W     = 32,
   parameter int N_IN  = 10,
   parameter int N_OUT = 15
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [N_IN-1:0][W-1:0]      values,
   output logic [N_OUT-1:0][W-1:0]     result,
   output logic                        busy,
   output logic                        done
);

   localparam int CW = $clog2(W);
   localparam int PW = 6;                 // holds -10..20 per-bit row sum

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   function automatic logic signed [PW-1:0] coef(input int r, input int c);
      int m;
      m = ((r + 2 * c) % 4) - 1;
      return PW'(m);
   endfunction

   logic [0:0]                 state_q, state_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic [N_IN-1:0][W-1:0]     sh_q, sh_d;
   logic [N_OUT-1:0][W-1:0]    acc_q, acc_d;
   logic [N_OUT-1:0][W-1:0]    result_q, result_d;
   logic                       done_q, done_d;
   logic [N_OUT-1:0][PW-1:0]   partial;
   logic [N_OUT-1:0][W-1:0]    addend;
   logic                       accept;
   logic                       last_bit;

   // state register and datapath flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         sh_q     <= '0;
         acc_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sh_q     <= sh_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign accept   = (state_q == ST_IDLE) && start;
   assign last_bit = (cnt_q == CW'(W - 1));

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start)    state_d = ST_RUN;
         ST_RUN:  if (last_bit) state_d = ST_IDLE;
         default:               state_d = ST_IDLE;
      endcase
   end

   // per-row signed sum of the current serial bits, weighted by 2^k
   always_comb begin
      for (int r = 0; r < N_OUT; r++) begin
         partial[r] = '0;
         for (int c = 0; c < N_IN; c++) begin
            partial[r] = partial[r] + (sh_q[c][0] ? coef(r, c) : PW'(0));
         end
         addend[r] = {{(W-PW){partial[r][PW-1]}}, partial[r]} << cnt_q;
      end
   end

   always_comb begin
      sh_d     = sh_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      done_d   = 1'b0;
      if (accept) begin
         sh_d  = values;
         acc_d = '0;
         cnt_d = '0;
`ifdef BSMM_RESULT_CLEAR_EN
         result_d = '0;
`else
         result_d = result_q;
`endif
      end else if (state_q == ST_RUN) begin
         for (int r = 0; r < N_OUT; r++) begin
            acc_d[r] = acc_q[r] + addend[r];
         end
         for (int c = 0; c < N_IN; c++) begin
            sh_d[c] = sh_q[c] >> 1;
         end
         cnt_d = cnt_q + CW'(1);
         if (last_bit) begin
            result_d = acc_d;
            done_d   = 1'b1;
            cnt_d    = '0;
         end
      end
   end

   // outputs
   always_comb begin
      busy   = (state_q == ST_RUN);
      done   = done_q;
      result = result_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_bit_serial_matrix_multiply_specific.sv
// ============================================================================
// Module  : tb_bit_serial_matrix_multiply_specific
// Brief   : Directed self-checking bench for bit_serial_matrix_multiply_specific.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_serial_matrix_multiply_specific;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  start;
   logic [9:0][31:0]      values;
   logic [14:0][31:0]     result;
   logic                  busy;
   logic                  done;

   int checks = 0;
   int errors = 0;

   bit_serial_matrix_multiply_specific dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .values (values),
      .result (result),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_rows(input string tag, input logic [31:0] p0, input logic [31:0] p1,
                           input logic [31:0] p2, input logic [31:0] p3);
      logic [31:0] e;
      for (int r = 0; r < 15; r++) begin
         case (r % 4)
            0:       e = p0;
            1:       e = p1;
            2:       e = p2;
            default: e = p3;
         endcase
         chk($sformatf("%s_row%0d", tag, r), result[r], e);
      end
   endtask

   // Starts a run at the current negedge and returns at the negedge where done
   // is high. prev1 is the row-1 result expected to still be visible once busy.
   task automatic run(input logic [9:0][31:0] v, input int inject_at, input logic [31:0] prev1);
      int lat;
      int bcnt;
      values = v;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
`ifdef BSMM_RESULT_CLEAR_EN
      chk("hold_at_start", result[1], 32'h0);
`else
      chk("hold_at_start", result[1], prev1);
`endif
      lat  = 0;
      bcnt = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) bcnt++;
         if (lat == inject_at) begin
            start  = 1'b1;
            values = {10{32'h5555_5555}};
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      chk("latency", lat, 32);
      chk("busy_cycles", bcnt, 32);
   endtask

   logic [9:0][31:0] v_ones, v_col, v_mix, v_ovf;
   logic             done_seen;

   initial begin
      v_ones = '0;
      for (int c = 0; c < 10; c++) v_ones[c] = 32'd1;
      v_col    = '0;
      v_col[0] = 32'd7;
      v_mix    = '0;
      v_mix[0] = 32'd1;   v_mix[1] = 32'd3;   v_mix[2] = 32'd5;   v_mix[3] = 32'd19;
      v_mix[4] = 32'd24;  v_mix[5] = 32'd12;  v_mix[6] = 32'd23;  v_mix[7] = 32'd135;
      v_mix[8] = 32'hFFFF_FFE9;               v_mix[9] = 32'd20;
      v_ovf    = '0;
      v_ovf[1] = 32'h7FFF_FFFF;

      rst_n  = 1'b0;
      start  = 1'b0;
      values = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_done", {31'b0, done}, 32'd0);
      chk_rows("reset_result", 32'h0, 32'h0, 32'h0, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      run(v_ones, -1, 32'h0);
      chk_rows("ones", 32'd0, 32'd10, 32'd0, 32'd10);
      @(negedge clk);
      chk("done_one_cycle", {31'b0, done}, 32'd0);
      chk("result_holds", result[1], 32'd10);

      run(v_col, -1, 32'd10);
      chk_rows("col0", 32'hFFFF_FFF9, 32'd0, 32'd7, 32'd14);

      // new start on the done cycle must be accepted
      run(v_mix, -1, 32'd0);
      chk_rows("mixed", 32'd159, 32'd378, 32'hFFFF_FF61, 32'd60);
      @(negedge clk);

      // a start pulsed mid-run with other operands must be ignored
      run(v_ovf, 10, 32'd378);
      chk_rows("ovf", 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0001, 32'h0);
      @(negedge clk);

      values = v_mix;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk_rows("abort_result", 32'h0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      rst_n     = 1'b1;
      done_seen = 1'b0;
      for (int i = 0; i < 35; i++) begin
         @(negedge clk);
         if (done === 1'b1) done_seen = 1'b1;
      end
      chk("abort_no_done", {31'b0, done_seen}, 32'd0);
      chk("abort_idle", {31'b0, busy}, 32'd0);

      run(v_mix, -1, 32'h0);
      chk_rows("after_abort", 32'd159, 32'd378, 32'hFFFF_FF61, 32'd60);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
